axi_wr_monitor: RTL and testbench
=================================

AXI_WR_MONITOR -- requirements
Module: axi_wr_monitor

Interface
REQ-001 SHALL have parameter ADDR_W, default 16: AWADDR width.
REQ-002 SHALL have parameter DATA_W, default 32: WDATA width; legal values 32, 64, 128.
REQ-003 SHALL have parameter DEPTH, default 4: per-queue entry count; power of two, 2..16.
REQ-004 SHALL have port CLK, input, 1: the single clock; all logic rises on it.
REQ-005 SHALL have port RESET, input, 1: synchronous, active-low reset (0 = reset).
REQ-006 SHALL have AW ports AWADDR[ADDR_W], AWLEN[8], AWSIZE[3], AWBURST[2], AWVALID, AWREADY, all inputs, sampled only.
REQ-007 SHALL have W ports WDATA[DATA_W], WLAST, WVALID, WREADY, all inputs, sampled only.
REQ-008 SHALL have B ports BRESP[2], BVALID, BREADY, all inputs, sampled only.
REQ-009 SHALL have outputs err_len, err_wlast_missing, err_overflow, err_b_early, err_size, err_resp: 1-bit each, one-cycle pulses.
REQ-010 SHALL have output err_sticky, 1: OR of all error pulses since reset.
REQ-011 SHALL have output txn_count, 16: count of completed B handshakes.
REQ-012 SHALL have output outstanding, $clog2(DEPTH)+1: AW accepted minus B completed.

Function
REQ-013 SHALL define an AW handshake as AWVALID&&AWREADY, a W beat as WVALID&&WREADY, and a B handshake as BVALID&&BREADY, all sampled at the CLK edge.
REQ-014 SHALL push AWLEN+1 (9 bits) into the AW queue on an AW handshake; if the queue is full, it SHALL drop the entry and pulse err_overflow.
REQ-015 SHALL pulse err_size on an AW handshake with AWSIZE > log2(DATA_W/8), or with AWBURST==WRAP and AWLEN not in {1,3,7,15}.
REQ-016 SHALL use a 9-bit beat counter that increments on each W beat.
  - On a beat with WLAST=1: push count+1 into the W queue, then clear the counter.
REQ-017 SHALL treat a 256th beat without WLAST as follows: pulse err_wlast_missing, push 256, clear the counter.
REQ-018 SHALL accept W bursts that complete before their AW; this is legal and no error.
REQ-019 SHALL, in any cycle where both queues are non-empty, pop one entry from each and compare them.
  - On mismatch: pulse err_len.
  - In either case: increment the 5-bit matched counter.
REQ-020 SHALL handle a W-queue-full push like an AW-queue-full push: drop the entry and pulse err_overflow.
REQ-021 SHALL, on a B handshake with matched==0, pulse err_b_early and leave txn_count unchanged.
  - Otherwise: decrement matched and increment txn_count (wraps at 2^16).
REQ-022 SHALL pulse err_resp on any accepted B handshake with BRESP != OKAY (2'b00).
REQ-023 SHALL resolve same-cycle events (push+pop on one queue, compare-pop plus B handshake) in that same cycle.
  - Net counts SHALL be exact.
  - A full queue with simultaneous pop SHALL accept the push.
REQ-024 SHALL count outstanding up on AW push and down on a valid B handshake, saturating at 0 and DEPTH.
REQ-025 SHALL register every error pulse: it appears exactly one cycle after the triggering edge and lasts one cycle.

Reset
REQ-026 SHALL, while RESET==0 at a CLK edge, clear both queues, the beat counter, matched, outstanding, txn_count, all error pulses and err_sticky.
REQ-027 SHALL discard a burst in progress when reset asserts mid-burst.
REQ-028 SHALL not count handshakes sampled while RESET==0.

Structure
REQ-029 SHALL place the following in shared package axi_vip_pkg:
  - burst_e enum (FIXED, INCR, WRAP)
  - resp_e enum (OKAY, EXOKAY, SLVERR, DECERR)
  - constant MAX_BEATS=256
REQ-030 SHALL instantiate the AW and W queues as two copies of one sub-module, axi_mon_fifo.
  - Parameters: WIDTH, DEPTH.
  - Ports: push, pop, full, empty, count.

Verification
REQ-031 SHALL cover: AW AWLEN=3, then 4 W beats with WLAST on beat 4, then B OKAY -> no errors, txn_count=1, outstanding=0.
REQ-032 SHALL cover: AW AWLEN=3, W WLAST on beat 3 -> err_len pulses once, one cycle after the compare.
REQ-033 SHALL cover: a W burst of 2 beats precedes AW AWLEN=1 -> no error; a following B increments txn_count.
REQ-034 SHALL cover, with DEPTH=4: 5 AW handshakes with no W -> err_overflow on the 5th, outstanding=4.
REQ-035 SHALL cover: B handshake before any matched burst -> err_b_early, txn_count unchanged; BRESP=SLVERR on a matched B -> err_resp.
REQ-036 SHALL cover: reset asserted after beat 2 of 4 -> all outputs 0, and a subsequent full burst completes cleanly.

Source files
------------

// File: rtl/axi_vip_pkg.sv
// Shared AXI types and constants used by the write-channel monitor.
package axi_vip_pkg;

    typedef enum logic [1:0] {
        FIXED = 2'b00,
        INCR  = 2'b01,
        WRAP  = 2'b10
    } burst_e;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_e;

    localparam int MAX_BEATS = 256;

    // WRAP bursts are only legal with 2, 4, 8 or 16 beats.
    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/axi_mon_fifo.sv
// Small synchronous FIFO holding burst lengths; a push into a full queue is
// accepted only when a pop happens in the same cycle.
module axi_mon_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // NOTE: storage has no reset; only pointers and count need defined values.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/axi_wr_monitor.sv
// Passive AXI write-channel monitor: pairs AW lengths with observed W burst
// lengths, checks B ordering/response, and reports one-cycle error pulses.
module axi_wr_monitor
    import axi_vip_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic [ADDR_W-1:0]         AWADDR,
    input  logic [7:0]                AWLEN,
    input  logic [2:0]                AWSIZE,
    input  logic [1:0]                AWBURST,
    input  logic                      AWVALID,
    input  logic                      AWREADY,
    input  logic [DATA_W-1:0]         WDATA,
    input  logic                      WLAST,
    input  logic                      WVALID,
    input  logic                      WREADY,
    input  logic [1:0]                BRESP,
    input  logic                      BVALID,
    input  logic                      BREADY,
    output logic                      err_len,
    output logic                      err_wlast_missing,
    output logic                      err_overflow,
    output logic                      err_b_early,
    output logic                      err_size,
    output logic                      err_resp,
    output logic                      err_sticky,
    output logic [15:0]               txn_count,
    output logic [$clog2(DEPTH):0]    outstanding
);

    localparam int       OUT_W    = $clog2(DEPTH) + 1;
    localparam logic [2:0] SIZE_MAX = 3'($clog2(DATA_W / 8));
    localparam logic [8:0] LAST_BEAT = 9'(MAX_BEATS - 1);

    logic aw_hs, w_beat, b_hs;
    assign aw_hs  = AWVALID && AWREADY;
    assign w_beat = WVALID && WREADY;
    assign b_hs   = BVALID && BREADY;

    logic [8:0] beat_cnt;
    logic [8:0] aw_len_ext;
    logic       w_push;
    logic [8:0] w_len;
    assign aw_len_ext = {1'b0, AWLEN} + 9'd1;
    assign w_push     = w_beat && (WLAST || beat_cnt == LAST_BEAT);
    assign w_len      = beat_cnt + 9'd1;

    logic [8:0]   aw_head, w_head;
    logic         aw_full, aw_empty, w_full, w_empty;
    logic [OUT_W-1:0] aw_count_unused, w_count_unused;
    logic         do_cmp;
    assign do_cmp = !aw_empty && !w_empty;

    axi_mon_fifo #(.WIDTH(9), .DEPTH(DEPTH)) u_aw_q (
        .clk   (CLK),
        .rst_n (RESET),
        .push  (aw_hs),
        .wdata (aw_len_ext),
        .pop   (do_cmp),
        .rdata (aw_head),
        .full  (aw_full),
        .empty (aw_empty),
        .count (aw_count_unused)
    );

    axi_mon_fifo #(.WIDTH(9), .DEPTH(DEPTH)) u_w_q (
        .clk   (CLK),
        .rst_n (RESET),
        .push  (w_push),
        .wdata (w_len),
        .pop   (do_cmp),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count_unused)
    );

    // A full queue still takes the push when the compare pops it this cycle.
    logic aw_drop, w_drop, aw_accept;
    assign aw_drop   = aw_hs  && aw_full && !do_cmp;
    assign w_drop    = w_push && w_full  && !do_cmp;
    assign aw_accept = aw_hs  && !aw_drop;

    logic [4:0] matched;
    logic       b_ok;
    assign b_ok = b_hs && (matched != 5'd0);

    logic len_d, wlast_d, ovf_d, early_d, size_d, resp_d;
    assign len_d   = do_cmp && (aw_head != w_head);
    assign wlast_d = w_beat && !WLAST && (beat_cnt == LAST_BEAT);
    assign ovf_d   = aw_drop || w_drop;
    assign early_d = b_hs && (matched == 5'd0);
    assign size_d  = aw_hs && ((AWSIZE > SIZE_MAX) ||
                               (burst_e'(AWBURST) == WRAP && !wrap_len_ok(AWLEN)));
    assign resp_d  = b_hs && (resp_e'(BRESP) != OKAY);

    logic unused_inputs;
    assign unused_inputs = ^{AWADDR, WDATA};

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            beat_cnt          <= '0;
            matched           <= '0;
            txn_count         <= '0;
            outstanding       <= '0;
            err_len           <= 1'b0;
            err_wlast_missing <= 1'b0;
            err_overflow      <= 1'b0;
            err_b_early       <= 1'b0;
            err_size          <= 1'b0;
            err_resp          <= 1'b0;
            err_sticky        <= 1'b0;
        end else begin
            if (w_push)      beat_cnt <= '0;
            else if (w_beat) beat_cnt <= beat_cnt + 9'd1;

            case ({do_cmp, b_ok})
                2'b10:   matched <= matched + 5'd1;
                2'b01:   matched <= matched - 5'd1;
                default: matched <= matched;
            endcase

            if (b_ok) txn_count <= txn_count + 16'd1;

            if (aw_accept && !b_ok && outstanding != OUT_W'(DEPTH))
                outstanding <= outstanding + 1'b1;
            else if (b_ok && !aw_accept && outstanding != '0)
                outstanding <= outstanding - 1'b1;

            err_len           <= len_d;
            err_wlast_missing <= wlast_d;
            err_overflow      <= ovf_d;
            err_b_early       <= early_d;
            err_size          <= size_d;
            err_resp          <= resp_d;
            err_sticky        <= err_sticky | len_d | wlast_d | ovf_d |
                                 early_d | size_d | resp_d;
        end
    end

endmodule

// File: tb/tb_axi_wr_monitor.sv
// Directed bench for axi_wr_monitor: burst pairing, overflow, early/err B,
// size checks, missing WLAST and mid-burst reset.
module tb_axi_wr_monitor;
    import axi_vip_pkg::*;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;

    logic              CLK = 1'b0;
    logic              RESET = 1'b0;
    logic [ADDR_W-1:0] AWADDR = '0;
    logic [7:0]        AWLEN = '0;
    logic [2:0]        AWSIZE = '0;
    logic [1:0]        AWBURST = '0;
    logic              AWVALID = 1'b0, AWREADY = 1'b0;
    logic [DATA_W-1:0] WDATA = '0;
    logic              WLAST = 1'b0, WVALID = 1'b0, WREADY = 1'b0;
    logic [1:0]        BRESP = '0;
    logic              BVALID = 1'b0, BREADY = 1'b0;
    logic              err_len, err_wlast_missing, err_overflow;
    logic              err_b_early, err_size, err_resp, err_sticky;
    logic [15:0]       txn_count;
    logic [$clog2(DEPTH):0] outstanding;

    axi_wr_monitor #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RESET(RESET),
        .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .err_len(err_len), .err_wlast_missing(err_wlast_missing),
        .err_overflow(err_overflow), .err_b_early(err_b_early),
        .err_size(err_size), .err_resp(err_resp), .err_sticky(err_sticky),
        .txn_count(txn_count), .outstanding(outstanding)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Pulse counters, sampled on the falling edge away from output updates.
    int n_len = 0, n_wl = 0, n_ovf = 0, n_early = 0, n_size = 0, n_resp = 0;
    always @(negedge CLK) begin
        if (err_len)           n_len++;
        if (err_wlast_missing) n_wl++;
        if (err_overflow)      n_ovf++;
        if (err_b_early)       n_early++;
        if (err_size)          n_size++;
        if (err_resp)          n_resp++;
    end

    int b_len, b_wl, b_ovf, b_early, b_size, b_resp;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic snap();
        b_len = n_len; b_wl = n_wl; b_ovf = n_ovf;
        b_early = n_early; b_size = n_size; b_resp = n_resp;
    endtask

    task automatic chk_errs(input string tag, input int len, input int wl, input int ovf,
                            input int early, input int size, input int resp);
        check({tag, ".err_len"},           32'(n_len - b_len),     32'(len));
        check({tag, ".err_wlast_missing"}, 32'(n_wl - b_wl),       32'(wl));
        check({tag, ".err_overflow"},      32'(n_ovf - b_ovf),     32'(ovf));
        check({tag, ".err_b_early"},       32'(n_early - b_early), 32'(early));
        check({tag, ".err_size"},          32'(n_size - b_size),   32'(size));
        check({tag, ".err_resp"},          32'(n_resp - b_resp),   32'(resp));
    endtask

    task automatic chk_all_zero(input string tag);
        check({tag, ".pulses"}, 32'({err_len, err_wlast_missing, err_overflow,
                                     err_b_early, err_size, err_resp}), 32'd0);
        check({tag, ".sticky"}, 32'(err_sticky), 32'd0);
        check({tag, ".txn"}, 32'(txn_count), 32'd0);
        check({tag, ".outstanding"}, 32'(outstanding), 32'd0);
    endtask

    task automatic do_reset();
        RESET = 1'b0;
        idle(2);
        RESET = 1'b1;
        snap();
    endtask

    task automatic do_aw(input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
        AWADDR = ADDR_W'($urandom);
        AWLEN = len; AWSIZE = size; AWBURST = burst;
        AWVALID = 1'b1; AWREADY = 1'b1;
        tick();
        AWVALID = 1'b0; AWREADY = 1'b0;
    endtask

    task automatic do_w(input int n, input bit last);
        for (int i = 0; i < n; i++) begin
            WDATA = DATA_W'($urandom);
            WVALID = 1'b1; WREADY = 1'b1;
            WLAST = last && (i == n - 1);
            tick();
        end
        WVALID = 1'b0; WREADY = 1'b0; WLAST = 1'b0;
    endtask

    task automatic do_b(input logic [1:0] resp);
        BRESP = resp; BVALID = 1'b1; BREADY = 1'b1;
        tick();
        BVALID = 1'b0; BREADY = 1'b0; BRESP = 2'b00;
    endtask

    initial begin
        do_reset();
        chk_all_zero("reset");

        // Clean burst; a valid-without-ready AW must not count.
        AWVALID = 1'b1; AWREADY = 1'b0; AWLEN = 8'd7;
        tick();
        AWVALID = 1'b0;
        do_aw(8'd3, 3'd2, INCR);
        check("clean.outstanding_after_aw", 32'(outstanding), 32'd1);
        do_w(4, 1'b1);
        idle(2);
        do_b(OKAY);
        idle(1);
        check("clean.txn", 32'(txn_count), 32'd1);
        check("clean.outstanding", 32'(outstanding), 32'd0);
        chk_errs("clean", 0, 0, 0, 0, 0, 0);

        // W burst completes before its AW.
        snap();
        do_w(2, 1'b1);
        do_aw(8'd1, 3'd2, INCR);
        idle(2);
        do_b(OKAY);
        idle(1);
        check("w_first.txn", 32'(txn_count), 32'd2);
        chk_errs("w_first", 0, 0, 0, 0, 0, 0);
        check("w_first.sticky", 32'(err_sticky), 32'd0);

        // Short burst: err_len one cycle after the compare.
        snap();
        do_aw(8'd3, 3'd2, INCR);
        do_w(3, 1'b1);
        check("len.before_cmp", 32'(err_len), 32'd0);
        tick();
        check("len.pulse", 32'(err_len), 32'd1);
        tick();
        check("len.pulse_end", 32'(err_len), 32'd0);
        check("len.sticky", 32'(err_sticky), 32'd1);
        do_b(OKAY);
        idle(1);
        check("len.txn", 32'(txn_count), 32'd3);
        chk_errs("len", 1, 0, 0, 0, 0, 0);

        // 256 beats with no WLAST: flagged, but length still matches AWLEN=255.
        snap();
        do_aw(8'd255, 3'd2, INCR);
        do_w(MAX_BEATS, 1'b0);
        check("wlast.pulse", 32'(err_wlast_missing), 32'd1);
        idle(2);
        do_b(OKAY);
        idle(1);
        check("wlast.txn", 32'(txn_count), 32'd4);
        chk_errs("wlast", 0, 1, 0, 0, 0, 0);

        // Early B, then SLVERR on a matched B.
        do_reset();
        do_b(OKAY);
        idle(1);
        check("early.txn", 32'(txn_count), 32'd0);
        chk_errs("early", 0, 0, 0, 1, 0, 0);
        snap();
        do_aw(8'd0, 3'd2, INCR);
        do_w(1, 1'b1);
        idle(2);
        do_b(SLVERR);
        idle(1);
        check("slverr.txn", 32'(txn_count), 32'd1);
        check("slverr.outstanding", 32'(outstanding), 32'd0);
        chk_errs("slverr", 0, 0, 0, 0, 0, 1);

        // AWSIZE and WRAP length legality.
        do_reset();
        do_aw(8'd0, 3'd3, INCR);
        do_aw(8'd2, 3'd2, WRAP);
        do_aw(8'd3, 3'd2, WRAP);
        do_aw(8'd0, 3'd2, FIXED);
        idle(1);
        chk_errs("size", 0, 0, 0, 0, 2, 0);
        check("size.outstanding", 32'(outstanding), 32'd4);

        // AW queue overflow on the fifth handshake.
        do_reset();
        for (int i = 0; i < 4; i++) do_aw(8'd0, 3'd2, INCR);
        check("ovf.no_pulse_yet", 32'(err_overflow), 32'd0);
        do_aw(8'd0, 3'd2, INCR);
        check("ovf.pulse", 32'(err_overflow), 32'd1);
        idle(1);
        check("ovf.outstanding", 32'(outstanding), 32'd4);
        chk_errs("ovf", 0, 0, 1, 0, 0, 0);

        // Reset after beat 2 of 4; handshakes during reset are ignored.
        do_reset();
        do_aw(8'd3, 3'd2, INCR);
        do_w(2, 1'b0);
        RESET = 1'b0;
        WVALID = 1'b1; WREADY = 1'b1; AWVALID = 1'b1; AWREADY = 1'b1;
        tick();
        WVALID = 1'b0; WREADY = 1'b0; AWVALID = 1'b0; AWREADY = 1'b0;
        RESET = 1'b1;
        snap();
        chk_all_zero("midreset");
        do_aw(8'd3, 3'd2, INCR);
        do_w(4, 1'b1);
        idle(2);
        do_b(OKAY);
        idle(1);
        check("midreset.txn", 32'(txn_count), 32'd1);
        check("midreset.outstanding", 32'(outstanding), 32'd0);
        check("midreset.sticky", 32'(err_sticky), 32'd0);
        chk_errs("midreset", 0, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
